// File: rtl/cu_seq_pkg.sv
// Shared constants, class codes and state encoding for the CU instruction sequencer.
package cu_seq_pkg;

   localparam int DEF_INSTR_WIDTH = 20;
   localparam int DEF_PC_BITS     = 5;
   localparam int DEF_STALL_CNT_W = 8;

   localparam logic [1:0] CLS_HALT  = 2'b00;
   localparam logic [1:0] CLS_STD   = 2'b01;
   localparam logic [1:0] CLS_LOAD  = 2'b10;
   localparam logic [1:0] CLS_STORE = 2'b11;

   localparam int HOLD_STD   = 3;
   localparam int HOLD_LOAD  = 4;
   localparam int HOLD_STORE = 3;
   localparam int BUBBLE_LEN = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH0,
      S_PRIME,
      S_ISSUE,
      S_BUBBLE,
      S_HALTED
   } seq_state_e;

   // Cycles the CU FSM needs for one instruction of the given class.
   function automatic logic [2:0] hold_of(input logic [1:0] cls);
      case (cls)
         CLS_LOAD:  return 3'(HOLD_LOAD);
         CLS_STORE: return 3'(HOLD_STORE);
         default:   return 3'(HOLD_STD);
      endcase
   endfunction

endpackage

// File: rtl/cu_seq_prefetch_buf.sv
// One-entry prefetch buffer owning the imem req/valid handshake.
module cu_seq_prefetch_buf #(
   parameter int DW = 20,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          launch,
   input  logic [AW-1:0] launch_addr,
   input  logic          clear,
   input  logic          pop,
   input  logic          bypass,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_valid,
   input  logic [DW-1:0] imem_rdata,
   output logic          accept,
   output logic          full,
   output logic [DW-1:0] data
);

   logic          pend_q, pend_d;
   logic          full_q, full_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      pend_d = pend_q;
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      accept = pend_q & imem_valid;
      if (accept) begin
         pend_d = 1'b0;
         // A bypassed word goes straight to the consumer and never fills the entry.
         if (!bypass) begin
            full_d = 1'b1;
            data_d = imem_rdata;
         end
      end
      if (pop) full_d = 1'b0;
      if (clear) begin
         pend_d = 1'b0;
         full_d = 1'b0;
      end
      if (launch) begin
         pend_d = 1'b1;
         addr_d = launch_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_q <= 1'b0;
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         pend_q <= pend_d;
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign imem_req  = pend_q;
   assign imem_addr = addr_q;
   assign full      = full_q;
   assign data      = data_q;

endmodule

// File: rtl/cu_instr_sequencer.sv
// Program sequencer feeding the multi-cycle CU; holds each word for its class time.
// Optional single-step mode (extra `step` input) is enabled by CU_SEQ_SINGLE_STEP_EN.
module cu_instr_sequencer
   import cu_seq_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int PC_BITS     = DEF_PC_BITS,
   parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   halt_req,
`ifdef CU_SEQ_SINGLE_STEP_EN
   input  logic                   step,
`endif
   output logic                   imem_req,
   output logic [PC_BITS-1:0]     imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   imem_valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_BITS-1:0]     pc,
   output logic                   busy,
   output logic                   done,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   seq_state_e             state_q, state_d;
   logic [INSTR_WIDTH-1:0] cur_q, cur_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   logic                   launch, clear, pop, bypass, accept, buf_full;
   logic [PC_BITS-1:0]     launch_addr;
   logic [INSTR_WIDTH-1:0] buf_data;
   logic [1:0]             buf_cls, rd_cls;
   logic                   boundary, step_go, from_cur;

`ifdef CU_SEQ_SINGLE_STEP_EN
   logic step_pend_q, step_pend_d, primed_q, primed_d;
`endif

   assign buf_cls = buf_data[INSTR_WIDTH-1 -: 2];
   assign rd_cls  = imem_rdata[INSTR_WIDTH-1 -: 2];

   cu_seq_prefetch_buf #(.DW(INSTR_WIDTH), .AW(PC_BITS)) u_pbuf (
      .clk         (clk),
      .rst         (rst),
      .launch      (launch),
      .launch_addr (launch_addr),
      .clear       (clear),
      .pop         (pop),
      .bypass      (bypass),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .accept      (accept),
      .full        (buf_full),
      .data        (buf_data)
   );

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      stall_d     = stall_q;
      launch      = 1'b0;
      launch_addr = '0;
      clear       = 1'b0;
      pop         = 1'b0;
      bypass      = 1'b0;
      boundary    = 1'b0;
`ifdef CU_SEQ_SINGLE_STEP_EN
      step_pend_d = step_pend_q | step;
      primed_d    = primed_q;
      step_go     = step_pend_q;
      from_cur    = primed_q;
`else
      step_go     = 1'b1;
      from_cur    = (state_q == S_PRIME);
`endif

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d     = S_FETCH0;
               pc_d        = '0;
               stall_d     = '0;
               clear       = 1'b1;
               launch      = 1'b1;
               launch_addr = '0;
`ifdef CU_SEQ_SINGLE_STEP_EN
               step_pend_d = 1'b0;
               primed_d    = 1'b0;
`endif
            end
         end
         S_FETCH0: begin
            bypass = 1'b1;
            if (accept) begin
               if (rd_cls == CLS_HALT) begin
                  state_d = S_HALTED;
               end else begin
                  cur_d   = imem_rdata;
                  state_d = S_PRIME;
`ifdef CU_SEQ_SINGLE_STEP_EN
                  primed_d = 1'b1;
`endif
               end
            end
         end
         S_PRIME: boundary = 1'b1;
         S_ISSUE, S_BUBBLE: begin
            if (cnt_q == 3'd1) boundary = 1'b1;
            else               cnt_d = cnt_q - 3'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // Instruction boundary: the PRIME word moves into its hold without a halt check.
      if (boundary) begin
         if (state_q != S_PRIME && halt_req) begin
            state_d = S_HALTED;
            clear   = 1'b1;
         end else if (!from_cur && buf_full && buf_cls == CLS_HALT) begin
            state_d = S_HALTED;
            clear   = 1'b1;
         end else if (!step_go) begin
            state_d = S_BUBBLE;
            cnt_d   = 3'(BUBBLE_LEN);
         end else if (from_cur) begin
            state_d     = S_ISSUE;
            cnt_d       = hold_of(cur_q[INSTR_WIDTH-1 -: 2]);
            launch      = 1'b1;
            launch_addr = pc_q + 1'b1;
`ifdef CU_SEQ_SINGLE_STEP_EN
            primed_d    = 1'b0;
            step_pend_d = step;
`endif
         end else if (buf_full) begin
            state_d     = S_ISSUE;
            cur_d       = buf_data;
            pc_d        = pc_q + 1'b1;
            cnt_d       = hold_of(buf_cls);
            pop         = 1'b1;
            launch      = 1'b1;
            launch_addr = pc_q + 2'd2;
`ifdef CU_SEQ_SINGLE_STEP_EN
            step_pend_d = step;
`endif
         end else begin
            state_d = S_BUBBLE;
            cnt_d   = 3'(BUBBLE_LEN);
            if (stall_q != '1) stall_d = stall_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

`ifdef CU_SEQ_SINGLE_STEP_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         step_pend_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         step_pend_q <= step_pend_d;
         primed_q    <= primed_d;
      end
   end
`endif

   assign instr     = (state_q == S_PRIME || state_q == S_ISSUE) ? cur_q : '0;
   assign pc        = pc_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign done      = (state_q == S_HALTED);
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cu_instr_sequencer.sv
// Self-checking bench for cu_instr_sequencer: directed tables plus randomized runs
// against a timeline model built from instruction hold times and fetch delays.
module tb_cu_instr_sequencer;
   import cu_seq_pkg::*;

   localparam int MAXT = 400;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, halt_req = 1'b0, spur = 1'b0;
`ifdef CU_SEQ_SINGLE_STEP_EN
   logic step = 1'b1;
   int   step_period = 0;
`endif
   logic        imem_req, imem_valid, busy, done;
   logic [4:0]  imem_addr, pc;
   logic [19:0] imem_rdata, instr;
   logic [7:0]  stall_cnt;

   cu_instr_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
`ifdef CU_SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .instr(instr), .pc(pc), .busy(busy),
      .done(done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Memory: fetch n answers after dly[n] request cycles; spurious valids while idle.
   logic [19:0] prog [32];
   int          dly [256];
   int          fetch_n = 0, wait_cnt = 0;

   always_comb begin
      imem_rdata = prog[imem_addr];
      if (imem_req) imem_valid = (wait_cnt >= dly[fetch_n % 256]);
      else          imem_valid = spur;
      if (!imem_req && spur) imem_rdata = 20'h4F00D;
   end

   always @(posedge clk) begin
      if (start) fetch_n <= 0;
      else if (imem_req && imem_valid) fetch_n <= fetch_n + 1;
      if (!imem_req || imem_valid) wait_cnt <= 0;
      else                         wait_cnt <= wait_cnt + 1;
   end

   logic [19:0] exp_instr [MAXT], act_instr [MAXT];
   logic [4:0]  exp_pc    [MAXT], act_pc    [MAXT];
   logic        exp_busy  [MAXT], act_busy  [MAXT];
   logic        exp_done  [MAXT], act_done  [MAXT];
   logic [7:0]  exp_stall [MAXT], act_stall [MAXT];
   logic        act_req   [MAXT];

   int total = 0, bad = 0, nprint = 0;

   task automatic chk(input string nm, input int t, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         if (nprint < 40) $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, e);
         nprint++;
      end
   endtask

   task automatic put(input int t, input logic [19:0] w, input int p, input int st);
      if (t < MAXT) begin
         exp_instr[t] = w; exp_pc[t] = 5'(p); exp_busy[t] = 1'b1;
         exp_done[t] = 1'b0; exp_stall[t] = 8'(st);
      end
   endtask

   task automatic fill_halt(input int t0, input int p, input int st);
      for (int t = t0; t < MAXT; t++) begin
         exp_instr[t] = '0; exp_pc[t] = 5'(p); exp_busy[t] = 1'b0;
         exp_done[t] = 1'b1; exp_stall[t] = 8'(st);
      end
   endtask

   // Timeline model: t=0 is the first cycle after start is sampled.
   task automatic model(input int halt_at);
      int s, e, c, fv, n, p, st, h;
      logic [19:0] w, nxt;
      bit halted;
      for (int t = 0; t < MAXT; t++) put(t, '0, 0, 0);
      c = dly[0];
      w = prog[0];
      if (w[19:18] == 2'b00) begin fill_halt(c + 1, 0, 0); return; end
      put(c + 1, w, 0, 0);
      s = c + 2; p = 0; n = 1; st = 0;
      forever begin
         h = (w[19:18] == 2'b10) ? HOLD_LOAD : (w[19:18] == 2'b11) ? HOLD_STORE : HOLD_STD;
         e = s + h - 1;
         for (int t = s; t <= e; t++) put(t, w, p, st);
         fv = s + dly[n % 256] + 1;
         c = e;
         halted = 1'b0;
         forever begin
            if (c >= halt_at) begin halted = 1'b1; break; end
            if (fv <= c) break;
            if (st < 255) st++;
            for (int t = c + 1; t <= c + BUBBLE_LEN; t++) put(t, '0, p, st);
            c += BUBBLE_LEN;
            if (c >= MAXT) return;
         end
         nxt = prog[(p + 1) % 32];
         if (!halted && nxt[19:18] == 2'b00) halted = 1'b1;
         if (halted) begin fill_halt(c + 1, p, st); return; end
         p = (p + 1) % 32; w = nxt; n++; s = c + 1;
         if (s >= MAXT) return;
      end
   endtask

   // Called at #1 after a posedge; pulses start and records ncyc cycles of outputs.
   task automatic run(input int halt_at, input int ncyc, input bit spur_on, input bit do_rst);
      if (do_rst) begin rst = 1'b0; @(posedge clk); #1 rst = 1'b1; end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 0; t < ncyc; t++) begin
         halt_req = (t >= halt_at);
         spur = spur_on && ($urandom_range(0, 3) == 0);
`ifdef CU_SEQ_SINGLE_STEP_EN
         step = (step_period == 0) || (t % step_period == step_period - 1);
`endif
         @(negedge clk);
         act_instr[t] = instr; act_pc[t] = pc; act_busy[t] = busy;
         act_done[t] = done; act_stall[t] = stall_cnt; act_req[t] = imem_req;
         @(posedge clk); #1;
      end
      halt_req = 1'b0; spur = 1'b0;
   endtask

   task automatic compare_all(input string nm, input int ncyc);
      for (int t = 0; t < ncyc; t++) begin
         chk({nm, ".instr"}, t, 32'(act_instr[t]), 32'(exp_instr[t]));
         chk({nm, ".pc"},    t, 32'(act_pc[t]),    32'(exp_pc[t]));
         chk({nm, ".busy"},  t, 32'(act_busy[t]),  32'(exp_busy[t]));
         chk({nm, ".done"},  t, 32'(act_done[t]),  32'(exp_done[t]));
         chk({nm, ".stall"}, t, 32'(act_stall[t]), 32'(exp_stall[t]));
      end
   endtask

   task automatic load_prog1();
      for (int a = 0; a < 32; a++) prog[a] = '0;
      prog[0] = 20'h41230; prog[1] = 20'h88040; prog[2] = 20'hC4050; prog[3] = 20'h00000;
      for (int n = 0; n < 256; n++) dly[n] = 0;
   endtask

   task automatic load_wrap();
      for (int a = 0; a < 32; a++) prog[a] = {2'b01, 18'($urandom)};
      for (int n = 0; n < 256; n++) dly[n] = 0;
   endtask

   typedef struct {
      int          sc;
      int          t;
      logic [19:0] instr;
      logic [4:0]  pc;
      logic        done;
      logic [7:0]  stall;
   } vec_t;
   vec_t tab [$];

   task automatic check_tab(input int sc);
      foreach (tab[i]) if (tab[i].sc == sc) begin
         chk("tab.instr", tab[i].t, 32'(act_instr[tab[i].t]), 32'(tab[i].instr));
         chk("tab.pc",    tab[i].t, 32'(act_pc[tab[i].t]),    32'(tab[i].pc));
         chk("tab.done",  tab[i].t, 32'(act_done[tab[i].t]),  32'(tab[i].done));
         chk("tab.stall", tab[i].t, 32'(act_stall[tab[i].t]), 32'(tab[i].stall));
      end
   endtask

   initial begin
      int ha;
      tab.push_back('{1,  0, 20'h00000, 5'd0, 1'b0, 8'd0});
      tab.push_back('{1,  1, 20'h41230, 5'd0, 1'b0, 8'd0});
      tab.push_back('{1,  4, 20'h41230, 5'd0, 1'b0, 8'd0});
      tab.push_back('{1,  5, 20'h88040, 5'd1, 1'b0, 8'd0});
      tab.push_back('{1,  8, 20'h88040, 5'd1, 1'b0, 8'd0});
      tab.push_back('{1,  9, 20'hC4050, 5'd2, 1'b0, 8'd0});
      tab.push_back('{1, 11, 20'hC4050, 5'd2, 1'b0, 8'd0});
      tab.push_back('{1, 12, 20'h00000, 5'd2, 1'b1, 8'd0});
      tab.push_back('{1, 20, 20'h00000, 5'd2, 1'b1, 8'd0});
      tab.push_back('{2,  4, 20'h41230, 5'd0, 1'b0, 8'd0});
      tab.push_back('{2,  5, 20'h00000, 5'd0, 1'b0, 8'd1});
      tab.push_back('{2,  8, 20'h00000, 5'd0, 1'b0, 8'd1});
      tab.push_back('{2,  9, 20'h00000, 5'd0, 1'b0, 8'd2});
      tab.push_back('{2, 12, 20'h00000, 5'd0, 1'b0, 8'd2});
      tab.push_back('{2, 13, 20'h88040, 5'd1, 1'b0, 8'd2});
      tab.push_back('{2, 16, 20'h88040, 5'd1, 1'b0, 8'd2});
      tab.push_back('{2, 17, 20'hC4050, 5'd2, 1'b0, 8'd2});
      tab.push_back('{2, 20, 20'h00000, 5'd2, 1'b1, 8'd2});

      load_prog1();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst.instr", 0, 32'(instr), 0); chk("rst.pc", 0, 32'(pc), 0);
      chk("rst.req", 0, 32'(imem_req), 0); chk("rst.busy", 0, 32'(busy), 0);
      chk("rst.done", 0, 32'(done), 0); chk("rst.stall", 0, 32'(stall_cnt), 0);
      @(posedge clk); #1;

      // zero-latency program
      load_prog1();
      run(MAXT, 30, 1'b0, 1'b1);
      check_tab(1);
      model(MAXT); compare_all("zero", 30);

      // word 1 arrives late: two bubbles
      load_prog1(); dly[1] = 6;
      run(MAXT, 30, 1'b0, 1'b1);
      check_tab(2);
      model(MAXT); compare_all("late", 30);

      // halt request in 2nd loadR hold cycle, spurious valids afterwards
      load_prog1(); prog[3] = 20'h45555;
      run(6, 30, 1'b1, 1'b1);
      chk("halt.held", 8, 32'(act_instr[8]), 32'h88040);
      chk("halt.done", 9, 32'(act_done[9]), 1);
      chk("halt.busy", 9, 32'(act_busy[9]), 0);
      chk("halt.pc", 25, 32'(act_pc[25]), 1);
      chk("halt.req", 12, 32'(act_req[12]), 0);
      model(6); compare_all("halt", 30);

      // reset during the 3rd loadR hold cycle, then restart without extra reset
      load_prog1();
      run(MAXT, 7, 1'b0, 1'b1);
      chk("mrst.pre", 6, 32'(act_instr[6]), 32'h88040);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst.instr", 8, 32'(instr), 0); chk("mrst.pc", 8, 32'(pc), 0);
      chk("mrst.req", 8, 32'(imem_req), 0); chk("mrst.busy", 8, 32'(busy), 0);
      chk("mrst.done", 8, 32'(done), 0);
      @(posedge clk); #1 rst = 1'b1;
      run(MAXT, 30, 1'b0, 1'b0);
      model(MAXT); compare_all("rerun", 30);

      // 32 std words, no HALT: pc wraps and word 0 re-issues back to back
      load_wrap();
      run(150, 200, 1'b0, 1'b1);
      chk("wrap.pc31", 97, 32'(act_pc[97]), 31);
      chk("wrap.pc0", 98, 32'(act_pc[98]), 0);
      chk("wrap.instr", 98, 32'(act_instr[98]), 32'(prog[0]));
      chk("wrap.stall", 98, 32'(act_stall[98]), 0);
      model(150); compare_all("wrap", 200);

      // randomized programs, delays, halts and spurious valids
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < 32; a++) prog[a] = {2'($urandom_range(1, 3)), 18'($urandom)};
         if (it == 0) prog[0] = '0;
         else if ($urandom_range(0, 1) == 1) prog[$urandom_range(1, 31)] = {2'b00, 18'($urandom)};
         for (int n = 0; n < 256; n++) dly[n] = $urandom_range(0, 9);
         ha = ($urandom_range(0, 2) == 0) ? MAXT : $urandom_range(5, 300);
         run(ha, MAXT, 1'b1, 1'b1);
         model(ha); compare_all("rand", MAXT);
      end

`ifdef CU_SEQ_SINGLE_STEP_EN
      // single step: one issue per pulse, NOP bubbles in between
      load_wrap(); step_period = 20;
      run(MAXT, 80, 1'b0, 1'b1);
      chk("step.wait", 30, 32'(act_instr[30]), 0);
      chk("step.i0", 23, 32'(act_instr[23]), 32'(prog[0]));
      chk("step.pc0", 30, 32'(act_pc[30]), 0);
      chk("step.i1", 42, 32'(act_instr[42]), 32'(prog[1]));
      chk("step.pc1", 50, 32'(act_pc[50]), 1);
      chk("step.i2", 65, 32'(act_instr[65]), 32'(prog[2]));
      chk("step.pc2", 79, 32'(act_pc[79]), 2);
      chk("step.stall", 79, 32'(act_stall[79]), 0);
      chk("step.busy", 79, 32'(act_busy[79]), 1);
      step_period = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
